// File: rtl/spi_m_pkg.sv
// Shared types and width helpers for the spi_master_p SPI master slice.
package spi_m_pkg;

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } mode_t;

    function automatic int tick_w(input int half_div);
        return $clog2(half_div) + 1;
    endfunction

    // Edge counter must hold 2*DATA_W without wrapping.
    function automatic int edge_w(input int data_w);
        return $clog2(2 * data_w + 1);
    endfunction

    function automatic int final_edge(input int data_w);
        return 2 * data_w - 1;
    endfunction

endpackage

// File: rtl/spi_master_p_if.sv
// Command/status and SPI pin bundle for spi_master_p.
// SPI_M_LOOPBACK_EN adds the loopback self-test request bit.
interface spi_master_p_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 1
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic              start;
    logic [DATA_W-1:0] data_in;
    logic [CS_W-1:0]   cs_sel;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic              miso;
    logic              mosi;
    logic              sck;
    logic [NUM_CS-1:0] cs_n;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              new_data;
`ifdef SPI_M_LOOPBACK_EN
    logic              loopback;

    modport master (output start, data_in, cs_sel, cpol, cpha, lsb_first, miso, loopback,
                    input  mosi, sck, cs_n, data_out, busy, new_data);
    modport slave  (input  start, data_in, cs_sel, cpol, cpha, lsb_first, miso, loopback,
                    output mosi, sck, cs_n, data_out, busy, new_data);
`else
    modport master (output start, data_in, cs_sel, cpol, cpha, lsb_first, miso,
                    input  mosi, sck, cs_n, data_out, busy, new_data);
    modport slave  (input  start, data_in, cs_sel, cpol, cpha, lsb_first, miso,
                    output mosi, sck, cs_n, data_out, busy, new_data);
`endif
endinterface

// File: rtl/spi_m_tick.sv
// Half-period divider: one-cycle tick every HALF_DIV enabled clocks.
module spi_m_tick
    import spi_m_pkg::*;
#(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int TW = tick_w(HALF_DIV);

    logic [TW-1:0] cnt;
    logic          at_end;

    assign at_end = (cnt == TW'(HALF_DIV - 1));
    assign tick   = en & at_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= '0;
        else if (clr)    cnt <= '0;
        else if (en)     cnt <= at_end ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/spi_master_p.sv
// SPI master: one full-duplex DATA_W-bit shift per start, all SPI modes, LSB/MSB first.
// SPI_M_LOOPBACK_EN adds a loopback self-test mode (RX from mosi, pins kept quiet).
module spi_master_p
    import spi_m_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int HALF_DIV = 2,
    parameter int NUM_CS   = 1
) (
    input logic           clk,
    input logic           rst_n,
    spi_master_p_if.slave bus
);
    localparam int              EW   = edge_w(DATA_W);
    localparam logic [EW-1:0]   LAST = EW'(final_edge(DATA_W));

    state_t            state, state_nx;
    mode_t             mode_q;
    logic              lb_q, lb_start, tick;
    logic [EW-1:0]     edge_cnt;
    logic [DATA_W-1:0] tx, rx;
    logic              rx_din, drive_edge, sample_edge;

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

`ifdef SPI_M_LOOPBACK_EN
    assign lb_start = bus.loopback;
`else
    assign lb_start = 1'b0;
`endif

    spi_m_tick #(.HALF_DIV(HALF_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state == IDLE),
        .en   (state != IDLE),
        .tick (tick)
    );

    // Even edge_cnt = leading sck edge; cpha picks which edge shifts and which samples.
    assign drive_edge  = (edge_cnt[0] != mode_q.cpha) && (edge_cnt != LAST);
    assign sample_edge = (edge_cnt[0] == mode_q.cpha);
    assign rx_din      = lb_q ? bus.mosi : bus.miso;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = LEAD;
            LEAD:    if (tick) state_nx = XFER;
            XFER:    if (tick && edge_cnt == LAST) state_nx = TRAIL;
            TRAIL:   if (tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= '0;
            lb_q         <= 1'b0;
            bus.sck      <= 1'b0;
            bus.mosi     <= 1'b0;
            bus.cs_n     <= '1;
            bus.data_out <= '0;
            bus.busy     <= 1'b0;
            bus.new_data <= 1'b0;
            tx           <= '0;
            rx           <= '0;
            edge_cnt     <= '0;
        end else begin
            bus.new_data <= 1'b0;
            case (state)
                IDLE: begin
                    bus.sck <= mode_q.cpol;
                    if (bus.start) begin
                        mode_q   <= '{cpol: bus.cpol, cpha: bus.cpha, lsb_first: bus.lsb_first};
                        lb_q     <= lb_start;
                        bus.sck  <= bus.cpol;
                        bus.busy <= 1'b1;
                        edge_cnt <= '0;
                        rx       <= '0;
                        if (!bus.cpha) begin
                            bus.mosi <= first_bit(bus.data_in, bus.lsb_first);
                            tx       <= shift_out(bus.data_in, bus.lsb_first);
                        end else begin
                            tx       <= bus.data_in;
                        end
                        // Out-of-range selects shift the one-hot off the top: nothing asserted.
                        if (!lb_start) bus.cs_n <= ~(NUM_CS'(1) << bus.cs_sel);
                    end
                end
                XFER: if (tick) begin
                    edge_cnt <= edge_cnt + 1'b1;
                    if (!lb_q) bus.sck <= ~bus.sck;
                    if (drive_edge) begin
                        bus.mosi <= first_bit(tx, mode_q.lsb_first);
                        tx       <= shift_out(tx, mode_q.lsb_first);
                    end
                    if (sample_edge)
                        rx <= mode_q.lsb_first ? {rx_din, rx[DATA_W-1:1]}
                                               : {rx[DATA_W-2:0], rx_din};
                end
                TRAIL: if (tick) begin
                    bus.cs_n     <= '1;
                    bus.busy     <= 1'b0;
                    bus.data_out <= rx;
                    bus.new_data <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_p.sv
// Scoreboard bench for spi_master_p: behavioural SPI slave, expected-word queue, monitor.
module tb_spi_master_p;
    localparam int DW = 8, HD = 2, NCS = 4;
    localparam int BUSY_CYC = HD * (2 * DW + 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_p_if #(.DATA_W(DW), .NUM_CS(NCS)) bus();
    spi_master_p #(.DATA_W(DW), .HALF_DIV(HD), .NUM_CS(NCS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [DW-1:0]  seq;
        logic [NCS-1:0] cs_mask;
        logic           cpol;
        logic           quiet;
    } exp_t;

    exp_t q[$];
    int checks = 0, failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Order in which bits appear on the wire, first bit at the MSB.
    function automatic logic [DW-1:0] seq_of(input logic [DW-1:0] d, input logic lsb);
        logic [DW-1:0] s;
        for (int i = 0; i < DW; i++) s[DW-1-i] = lsb ? d[i] : d[DW-1-i];
        return s;
    endfunction

    function automatic logic [NCS-1:0] mask_of(input logic [1:0] sel);
        logic [NCS-1:0] m;
        for (int i = 0; i < NCS; i++) m[i] = (i != int'(sel));
        return m;
    endfunction

    // Behavioural slave
    logic          cur_cpol = 0, cur_cpha = 0, cur_lsb = 0, loop_en = 0;
    logic [DW-1:0] sl_word = '0, sl_bits = '0;
    logic          slave_miso = 0, sl_act = 0, sl_sck = 0;
    int            sl_idx = 0, sl_cnt = 0;

    always_comb bus.miso = loop_en ? bus.mosi : slave_miso;

    function automatic logic sbit(input int i);
        return cur_lsb ? sl_word[i] : sl_word[DW-1-i];
    endfunction

    initial begin
        forever begin
            @(bus.cs_n or bus.sck);
            if (bus.cs_n == '1) sl_act = 0;
            else if (!sl_act) begin
                sl_act = 1; sl_idx = 0; sl_bits = '0; sl_cnt = 0; sl_sck = cur_cpol;
                if (!cur_cpha) slave_miso = sbit(0);
            end else if (bus.sck != sl_sck) begin
                sl_sck = bus.sck;
                if ((bus.sck != cur_cpol) ^ cur_cpha) begin
                    sl_bits = {sl_bits[DW-2:0], bus.mosi};
                    sl_cnt++;
                end else if (cur_cpha) begin
                    if (sl_idx < DW) slave_miso = sbit(sl_idx);
                    sl_idx++;
                end else begin
                    sl_idx++;
                    if (sl_idx < DW) slave_miso = sbit(sl_idx);
                end
            end
        end
    end

    // Monitor
    int   bcnt = 0, edges = 0;
    logic in_x = 0, cs_bad = 0, sckp = 0, first_sck = 0, nd_prev = 0;
    exp_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            bcnt = 0; edges = 0; in_x = 0; cs_bad = 0; nd_prev = 0;
        end else begin
            if (bus.busy) begin
                if (!in_x) begin
                    in_x = 1; bcnt = 0; edges = 0; cs_bad = 0;
                    sckp = bus.sck; first_sck = bus.sck;
                end
                bcnt++;
                if (bus.sck != sckp) edges++;
                sckp = bus.sck;
                if (q.size() > 0 && bus.cs_n != q[0].cs_mask) cs_bad = 1;
            end
            if (bus.new_data) begin
                in_x = 0;
                chk("new_data_single_pulse", int'(nd_prev), 0);
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_new_data: got data_out %0h expected no completion", bus.data_out);
                end else begin
                    e = q.pop_front();
                    chk("data_out", int'(bus.data_out), int'(e.data));
                    chk("busy_cycles", bcnt, BUSY_CYC);
                    chk("sck_edges", edges, e.quiet ? 0 : 2 * DW);
                    chk("cs_n_during_xfer", int'(cs_bad), 0);
                    chk("sck_idle_start", int'(first_sck), int'(e.cpol));
                    chk("sck_idle_end", int'(bus.sck), int'(e.cpol));
                    chk("cs_n_released", int'(bus.cs_n), int'({NCS{1'b1}}));
                    chk("busy_low_at_done", int'(bus.busy), 0);
                    if (!e.quiet) begin
                        chk("mosi_bit_order", int'(sl_bits), int'(e.seq));
                        chk("slave_sample_count", sl_cnt, DW);
                    end
                end
            end
            nd_prev = bus.new_data;
        end
    end

    task automatic xfer(input logic [DW-1:0] d, input logic [1:0] sel, input logic pol,
                        input logic pha, input logic lsb, input logic [DW-1:0] sw,
                        input logic lp, input logic lb);
        exp_t x;
        int   n;
        @(negedge clk);
        n = 0;
        while (bus.busy && n < 4 * BUSY_CYC) begin @(negedge clk); n++; end
        if (n >= 4 * BUSY_CYC) begin
            checks++; failures++;
            $display("FAIL idle_wait_timeout: busy still %0d expected 0", bus.busy);
        end
        cur_cpol = pol; cur_cpha = pha; cur_lsb = lsb; sl_word = sw; loop_en = lp;
        x.data    = (lp || lb) ? d : sw;
        x.seq     = seq_of(d, lsb);
        x.cs_mask = lb ? {NCS{1'b1}} : mask_of(sel);
        x.cpol    = pol;
        x.quiet   = lb;
        q.push_back(x);
        bus.start = 1; bus.data_in = d; bus.cs_sel = sel;
        bus.cpol = pol; bus.cpha = pha; bus.lsb_first = lsb;
`ifdef SPI_M_LOOPBACK_EN
        bus.loopback = lb;
`endif
        @(negedge clk);
        bus.start = 0;
    endtask

    initial begin
        bus.start = 0; bus.data_in = '0; bus.cs_sel = '0;
        bus.cpol = 0; bus.cpha = 0; bus.lsb_first = 0;
`ifdef SPI_M_LOOPBACK_EN
        bus.loopback = 0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_sck", int'(bus.sck), 0);
        chk("rst_mosi", int'(bus.mosi), 0);
        chk("rst_cs_n", int'(bus.cs_n), 'hF);
        chk("rst_data_out", int'(bus.data_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_new_data", int'(bus.new_data), 0);
        rst_n = 1;

        xfer(8'hA5, 2'd0, 0, 0, 0, 8'h00, 1, 0);   // mode 0, miso looped to mosi
        xfer(8'h96, 2'd1, 0, 1, 0, 8'h3C, 0, 0);   // mode 1
        xfer(8'h5E, 2'd2, 1, 0, 0, 8'h3C, 0, 0);   // mode 2
        xfer(8'hC3, 2'd3, 1, 1, 0, 8'h3C, 0, 0);   // mode 3
        xfer(8'h01, 2'd0, 0, 0, 1, 8'hFF, 0, 0);   // lsb first, miso held high
        xfer(8'h12, 2'd2, 0, 0, 0, 8'h81, 0, 0);   // back-to-back on cs 2 then 3
        xfer(8'h34, 2'd3, 1, 1, 1, 8'h7E, 0, 0);

        xfer(8'h33, 2'd1, 0, 1, 1, 8'hC5, 0, 0);   // stray start while busy
        repeat (10) @(negedge clk);
        bus.start = 1; bus.data_in = 8'hFF; bus.cs_sel = 2'd0;
        @(negedge clk);
        bus.start = 0;

        repeat (12)
            xfer(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), 0);

        // Reset in the middle of XFER
        xfer(8'h6B, 2'd1, 0, 0, 0, 8'h99, 0, 0);
        repeat (12) @(negedge clk);
        void'(q.pop_back());
        rst_n = 0;
        #1;
        chk("abort_cs_n", int'(bus.cs_n), 'hF);
        chk("abort_busy", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (5) @(negedge clk);
        chk("post_abort_busy", int'(bus.busy), 0);
        chk("post_abort_cs_n", int'(bus.cs_n), 'hF);
        chk("post_abort_data_out", int'(bus.data_out), 0);

        xfer(8'hE7, 2'd2, 1, 0, 1, 8'h2D, 0, 0);   // recovery after abort

`ifdef SPI_M_LOOPBACK_EN
        xfer(8'h5A, 2'd0, 0, 0, 0, 8'h00, 0, 1);
`endif

        @(negedge clk);
        begin
            int n = 0;
            while (bus.busy && n < 4 * BUSY_CYC) begin @(negedge clk); n++; end
            if (n >= 4 * BUSY_CYC) begin
                checks++; failures++;
                $display("FAIL final_idle_timeout: busy still %0d expected 0", bus.busy);
            end
        end
        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
